timer_clint: RTL and testbench

TIMER_CLINT -- requirements
Module: timer_clint

---
 rtl/timer_clint_if.sv | 16 +
 rtl/timer_clint.sv | 153 +++++++++++++++
 tb/tb_timer_clint.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/timer_clint_if.sv
// Register-bus bundle for timer_clint: write/read strobes, word address,
// write data and the registered read response.
interface timer_clint_if #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
);
  logic              wr_en;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  wdata;
  logic [WIDTH-1:0]  rdata;
  logic              rvalid;

  modport master (output wr_en, rd_en, addr, wdata, input rdata, rvalid);
  modport slave  (input wr_en, rd_en, addr, wdata, output rdata, rvalid);
endinterface

// File: rtl/timer_clint.sv
// Machine timer: prescaled mtime counter, NUM_CH compare channels with
// one-shot or periodic reload, sticky pending bits and a registered read port.
module timer_clint #(
  parameter int WIDTH      = 64,
  parameter int NUM_CH     = 2,
  parameter int PRESCALE_W = 8,
  parameter int CMP_RST    = 25,
  parameter int ADDR_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  timer_clint_if.slave      bus,
  output logic [NUM_CH-1:0] timer_interrupt,
  output logic              irq_any
);

  logic                  en_q, en_d;
  logic [PRESCALE_W-1:0] div_q, div_d;
  logic [PRESCALE_W-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]      mtime_q, mtime_d;
  logic                  tick;

  logic [NUM_CH-1:0]     pend_q, pend_d;
  logic [NUM_CH-1:0]     arm_q, arm_d;
  logic [NUM_CH-1:0]     perd_q, perd_d;
  logic [NUM_CH-1:0]     ie_q, ie_d;
  logic [NUM_CH-1:0]     irq_q, irq_d;
  logic [NUM_CH-1:0]     hit;
  logic [WIDTH-1:0]      cmp_q [NUM_CH];
  logic [WIDTH-1:0]      cmp_d [NUM_CH];
  logic [WIDTH-1:0]      per_q [NUM_CH];
  logic [WIDTH-1:0]      per_d [NUM_CH];

  logic [WIDTH-1:0]      rdata_q, rdata_d;
  logic                  rvalid_q;

  logic                  wr_ctrl, wr_mtime, wr_pend;
  logic [NUM_CH-1:0]     wr_cmp, wr_per, wr_chc;

  always_comb begin
    wr_ctrl  = bus.wr_en && (bus.addr == ADDR_W'(0));
    wr_mtime = bus.wr_en && (bus.addr == ADDR_W'(1));
    wr_pend  = bus.wr_en && (bus.addr == ADDR_W'(2));
    wr_cmp   = '0;
    wr_per   = '0;
    wr_chc   = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      wr_cmp[i] = bus.wr_en && (bus.addr == ADDR_W'(4 + 3*i));
      wr_per[i] = bus.wr_en && (bus.addr == ADDR_W'(5 + 3*i));
      wr_chc[i] = bus.wr_en && (bus.addr == ADDR_W'(6 + 3*i));
    end
  end

  // Prescaler and mtime; a software MTIME write beats the tick increment.
  always_comb begin
    tick    = en_q && (pc_q == div_q);
    pc_d    = (!en_q || tick) ? '0 : pc_q + PRESCALE_W'(1);
    mtime_d = mtime_q;
    if (wr_mtime)  mtime_d = bus.wdata;
    else if (tick) mtime_d = mtime_q + WIDTH'(1);
    en_d  = en_q;
    div_d = div_q;
    if (wr_ctrl) begin
      en_d  = bus.wdata[0];
      div_d = bus.wdata[8 +: PRESCALE_W];
    end
  end

  // Hardware effects of a hit are applied first, then software writes override.
  always_comb begin
    hit    = '0;
    arm_d  = arm_q;
    perd_d = perd_q;
    ie_d   = ie_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i]   = arm_q[i] && (mtime_q >= cmp_q[i]);
      cmp_d[i] = cmp_q[i];
      per_d[i] = per_q[i];
      if (hit[i]) begin
        if (perd_q[i] && (per_q[i] != '0)) cmp_d[i] = cmp_q[i] + per_q[i];
        else                               arm_d[i] = 1'b0;
      end
      if (wr_cmp[i]) cmp_d[i] = bus.wdata;
      if (wr_per[i]) per_d[i] = bus.wdata;
      if (wr_chc[i]) begin
        arm_d[i]  = bus.wdata[0];
        perd_d[i] = bus.wdata[1];
        ie_d[i]   = bus.wdata[2];
      end
    end
    pend_d = (pend_q & ~(wr_pend ? bus.wdata[NUM_CH-1:0] : '0)) | hit;
    irq_d  = pend_d & ie_d;
  end

  always_comb begin
    rdata_d = '0;
    if (bus.addr == ADDR_W'(0)) begin
      rdata_d[0]              = en_q;
      rdata_d[8 +: PRESCALE_W] = div_q;
    end else if (bus.addr == ADDR_W'(1)) begin
      rdata_d = mtime_q;
    end else if (bus.addr == ADDR_W'(2)) begin
      rdata_d[NUM_CH-1:0] = pend_q;
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (bus.addr == ADDR_W'(4 + 3*i)) rdata_d = cmp_q[i];
      if (bus.addr == ADDR_W'(5 + 3*i)) rdata_d = per_q[i];
      if (bus.addr == ADDR_W'(6 + 3*i)) rdata_d = {{(WIDTH-3){1'b0}}, ie_q[i], perd_q[i], arm_q[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q     <= 1'b0;
      div_q    <= '0;
      pc_q     <= '0;
      mtime_q  <= '0;
      pend_q   <= '0;
      arm_q    <= '0;
      perd_q   <= '0;
      ie_q     <= '0;
      irq_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cmp_q[i] <= WIDTH'(CMP_RST);
        per_q[i] <= '0;
      end
    end else begin
      en_q     <= en_d;
      div_q    <= div_d;
      pc_q     <= pc_d;
      mtime_q  <= mtime_d;
      pend_q   <= pend_d;
      arm_q    <= arm_d;
      perd_q   <= perd_d;
      ie_q     <= ie_d;
      irq_q    <= irq_d;
      rvalid_q <= bus.rd_en;
      if (bus.rd_en) rdata_q <= rdata_d;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        cmp_q[i] <= cmp_d[i];
        per_q[i] <= per_d[i];
      end
    end
  end

  assign bus.rdata       = rdata_q;
  assign bus.rvalid      = rvalid_q;
  assign timer_interrupt = irq_q;
  assign irq_any         = |irq_q;

endmodule

// File: tb/tb_timer_clint.sv
// Self-checking bench for timer_clint: directed scenarios plus a randomized
// run compared against a register-level behavioural model.
module tb_timer_clint;
  localparam int WIDTH   = 64;
  localparam int NUM_CH  = 2;
  localparam int PW      = 8;
  localparam int CMP_RST = 25;
  localparam int ADDR_W  = 5;
  localparam logic [WIDTH-1:0] ONES = '1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NUM_CH-1:0] timer_interrupt;
  logic irq_any;
  int checks = 0;
  int failures = 0;

  timer_clint_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  timer_clint #(.WIDTH(WIDTH), .NUM_CH(NUM_CH), .PRESCALE_W(PW),
                .CMP_RST(CMP_RST), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .timer_interrupt(timer_interrupt), .irq_any(irq_any)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit               m_en;
  int unsigned      m_div, m_pc;
  logic [WIDTH-1:0] m_mtime, m_rdata;
  logic [WIDTH-1:0] m_cmp [NUM_CH];
  logic [WIDTH-1:0] m_per [NUM_CH];
  bit               m_arm [NUM_CH];
  bit               m_pdc [NUM_CH];
  bit               m_ie  [NUM_CH];
  logic [NUM_CH-1:0] m_pend, m_irq;
  bit               m_rvalid;

  task automatic model_reset();
    m_en = 0; m_div = 0; m_pc = 0; m_mtime = '0; m_rdata = '0;
    m_pend = '0; m_irq = '0; m_rvalid = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      m_cmp[c] = WIDTH'(CMP_RST); m_per[c] = '0;
      m_arm[c] = 0; m_pdc[c] = 0; m_ie[c] = 0;
    end
  endtask

  function automatic logic [WIDTH-1:0] m_read(int unsigned a);
    logic [WIDTH-1:0] v;
    v = '0;
    if (a == 0) v = (WIDTH'(m_div) << 8) | WIDTH'(m_en);
    else if (a == 1) v = m_mtime;
    else if (a == 2) v = WIDTH'(m_pend);
    else if (a >= 4 && a < 4 + 3*NUM_CH) begin
      int unsigned c;
      c = (a - 4) / 3;
      case ((a - 4) % 3)
        0: v = m_cmp[c];
        1: v = m_per[c];
        default: v = WIDTH'({m_ie[c], m_pdc[c], m_arm[c]});
      endcase
    end
    return v;
  endfunction

  // Advance the model by one clock using the bus inputs currently driven,
  // then let the DUT take the same edge.
  task automatic step();
    bit wr, rd, tick;
    int unsigned a;
    logic [WIDTH-1:0] wd, rv;
    logic [NUM_CH-1:0] hit, clr;
    wr = bus.wr_en; rd = bus.rd_en; a = 32'(bus.addr); wd = bus.wdata;
    if (reset) model_reset();
    else begin
      rv   = m_read(a);
      tick = m_en && (m_pc == m_div);
      for (int c = 0; c < NUM_CH; c++) hit[c] = m_arm[c] && (m_mtime >= m_cmp[c]);
      m_pc = (m_en && !tick) ? (m_pc + 1) % (1 << PW) : 0;
      if (wr && a == 1) m_mtime = wd;
      else if (tick) m_mtime = m_mtime + 1;
      if (wr && a == 0) begin m_en = wd[0]; m_div = 32'(wd[8 +: PW]); end
      clr = (wr && a == 2) ? wd[NUM_CH-1:0] : '0;
      m_pend = (m_pend & ~clr) | hit;
      for (int c = 0; c < NUM_CH; c++) begin
        if (hit[c]) begin
          if (m_pdc[c] && m_per[c] != 0) m_cmp[c] = m_cmp[c] + m_per[c];
          else m_arm[c] = 0;
        end
        if (wr && a == 4 + 3*c) m_cmp[c] = wd;
        if (wr && a == 5 + 3*c) m_per[c] = wd;
        if (wr && a == 6 + 3*c) begin m_arm[c] = wd[0]; m_pdc[c] = wd[1]; m_ie[c] = wd[2]; end
        m_irq[c] = m_pend[c] & m_ie[c];
      end
      m_rvalid = rd;
      if (rd) m_rdata = rv;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic wr(int unsigned a, logic [WIDTH-1:0] d);
    bus.wr_en = 1'b1; bus.addr = ADDR_W'(a); bus.wdata = d;
    step();
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(int unsigned a, output logic [WIDTH-1:0] d, output logic v);
    bus.rd_en = 1'b1; bus.addr = ADDR_W'(a);
    step();
    bus.rd_en = 1'b0;
    d = bus.rdata; v = bus.rvalid;
  endtask

  task automatic do_reset();
    reset = 1'b1; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] d, exp;
    logic v;
    reset = 1'b1; bus.wr_en = 1'b1; bus.addr = 1; bus.wdata = 123;
    step();
    bus.wr_en = 1'b0; step(); reset = 1'b0;
    checks++;
    if (timer_interrupt !== '0 || irq_any !== 1'b0) begin
      failures++; $display("FAIL reset_irq: got %b/%b expected 0/0", timer_interrupt, irq_any);
    end
    checks++;
    if (bus.rvalid !== 1'b0 || bus.rdata !== '0) begin
      failures++; $display("FAIL reset_rd: got %b/%0h expected 0/0", bus.rvalid, bus.rdata);
    end
    for (int unsigned a = 0; a < 4 + 3*NUM_CH; a++) begin
      rd(a, d, v);
      exp = (a >= 4 && (a - 4) % 3 == 0) ? WIDTH'(CMP_RST) : '0;
      checks++;
      if (d !== exp || v !== 1'b1) begin
        failures++; $display("FAIL reset_reg%0d: got %0h/%b expected %0h/1", a, d, v, exp);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [WIDTH-1:0] d;
    logic v;
    int n;
    do_reset();
    wr(6, 5);
    wr(0, 1);
    n = 0;
    while (timer_interrupt[0] !== 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (n != 26) begin failures++; $display("FAIL oneshot_latency: got %0d cycles expected 26", n); end
    checks++;
    if (irq_any !== 1'b1) begin failures++; $display("FAIL oneshot_irq_any: got %b expected 1", irq_any); end
    rd(6, d, v);
    checks++;
    if (d !== 64'd4) begin failures++; $display("FAIL oneshot_disarm: got %0h expected 4", d); end
  endtask

  task automatic test_prescale();
    logic [WIDTH-1:0] d;
    logic v;
    do_reset();
    wr(0, (3 << 8) | 1);
    idle(40);
    rd(1, d, v);
    checks++;
    if (d !== 64'd10) begin failures++; $display("FAIL presc_40: got %0d expected 10", d); end
    idle(3);
    rd(1, d, v);
    checks++;
    if (d !== 64'd11) begin failures++; $display("FAIL presc_44: got %0d expected 11", d); end
    wr(0, 3 << 8);
    idle(10);
    rd(1, d, v);
    checks++;
    if (d !== 64'd11) begin failures++; $display("FAIL presc_hold: got %0d expected 11", d); end
    wr(0, (3 << 8) | 1);
    idle(3);
    rd(1, d, v);
    checks++;
    if (d !== 64'd11) begin failures++; $display("FAIL presc_restart_a: got %0d expected 11", d); end
    rd(1, d, v);
    checks++;
    if (d !== 64'd12) begin failures++; $display("FAIL presc_restart_b: got %0d expected 12", d); end
  endtask

  task automatic test_periodic();
    logic [WIDTH-1:0] d;
    logic v;
    int n;
    do_reset();
    wr(7, 10); wr(8, 5); wr(9, 7);
    wr(0, (7 << 8) | 1);
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (timer_interrupt[1] !== 1'b1 && n < 300) begin step(); n++; end
      checks++;
      if (n >= 300) begin failures++; $display("FAIL periodic_timeout%0d: got none expected irq", k); end
      rd(1, d, v);
      checks++;
      if (d !== 64'(10 + 5*k)) begin failures++; $display("FAIL periodic_hit%0d: got %0d expected %0d", k, d, 10 + 5*k); end
      wr(2, 2);
    end
    rd(7, d, v);
    checks++;
    if (d !== 64'd25) begin failures++; $display("FAIL periodic_cmp: got %0d expected 25", d); end
    rd(9, d, v);
    checks++;
    if (d !== 64'd7) begin failures++; $display("FAIL periodic_chctrl: got %0h expected 7", d); end
  endtask

  task automatic test_w1c_race();
    logic [WIDTH-1:0] d;
    logic v;
    do_reset();
    wr(4, 100); wr(6, 1); wr(1, 100);
    step();
    wr(6, 5);
    wr(2, 1);
    checks++;
    if (timer_interrupt[0] !== 1'b1) begin failures++; $display("FAIL race_irq: got %b expected 1", timer_interrupt[0]); end
    rd(2, d, v);
    checks++;
    if (d !== 64'd1) begin failures++; $display("FAIL race_pending: got %0h expected 1", d); end
    wr(2, 1);
    rd(2, d, v);
    checks++;
    if (d !== 64'd0 || timer_interrupt[0] !== 1'b0) begin
      failures++; $display("FAIL w1c_clear: got %0h/%b expected 0/0", d, timer_interrupt[0]);
    end
    // Software writes landing in a hit cycle
    wr(7, 50); wr(8, 4); wr(9, 3);
    wr(7, 200);
    rd(7, d, v);
    checks++;
    if (d !== 64'd200) begin failures++; $display("FAIL sw_cmp_prio: got %0d expected 200", d); end
    wr(4, 50); wr(6, 1);
    wr(6, 3);
    rd(6, d, v);
    checks++;
    if (d !== 64'd3) begin failures++; $display("FAIL sw_chctrl_prio: got %0h expected 3", d); end
    rd(6, d, v);
    checks++;
    if (d !== 64'd2) begin failures++; $display("FAIL period0_oneshot: got %0h expected 2", d); end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] d;
    logic v;
    do_reset();
    wr(4, ONES); wr(5, 2); wr(6, 7);
    wr(0, 1);
    wr(1, ONES);
    step();
    checks++;
    if (timer_interrupt[0] !== 1'b1) begin failures++; $display("FAIL wrap_irq: got %b expected 1", timer_interrupt[0]); end
    rd(4, d, v);
    checks++;
    if (d !== 64'd1) begin failures++; $display("FAIL wrap_reload: got %0h expected 1", d); end
    rd(4, d, v);
    checks++;
    if (d !== 64'd1) begin failures++; $display("FAIL wrap_hold: got %0h expected 1", d); end
    rd(4, d, v);
    checks++;
    if (d !== 64'd3) begin failures++; $display("FAIL wrap_refire: got %0h expected 3", d); end
    wr(0, 0); wr(1, ONES); wr(0, 1);
    rd(1, d, v);
    checks++;
    if (d !== ONES) begin failures++; $display("FAIL mtime_max: got %0h expected %0h", d, ONES); end
    rd(1, d, v);
    checks++;
    if (d !== 64'd0) begin failures++; $display("FAIL mtime_wrap: got %0h expected 0", d); end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] d;
    logic v;
    do_reset();
    wr(1, 5);
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = 1; bus.wdata = 77;
    step();
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    checks++;
    if (bus.rdata !== 64'd5 || bus.rvalid !== 1'b1) begin
      failures++; $display("FAIL rw_same: got %0d/%b expected 5/1", bus.rdata, bus.rvalid);
    end
    rd(1, d, v);
    checks++;
    if (d !== 64'd77) begin failures++; $display("FAIL rw_after: got %0d expected 77", d); end
    step();
    checks++;
    if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL rvalid_pulse: got %b expected 0", bus.rvalid); end
    wr(3, ONES); wr(31, ONES); wr(10, ONES);
    rd(3, d, v);
    checks++;
    if (d !== '0) begin failures++; $display("FAIL unmapped3: got %0h expected 0", d); end
    rd(10, d, v);
    checks++;
    if (d !== '0) begin failures++; $display("FAIL unmapped10: got %0h expected 0", d); end
    rd(1, d, v);
    checks++;
    if (d !== 64'd77) begin failures++; $display("FAIL unmapped_side: got %0d expected 77", d); end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] d;
    logic v;
    do_reset();
    wr(6, 5); wr(4, 3);
    wr(0, (2 << 8) | 1);
    idle(20);
    rd(1, d, v);
    checks++;
    if (timer_interrupt[0] !== 1'b1) begin failures++; $display("FAIL rstmid_pre: got %b expected 1", timer_interrupt[0]); end
    reset = 1'b1; bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.addr = 1; bus.wdata = 99;
    step();
    reset = 1'b0; bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    checks++;
    if (timer_interrupt !== '0 || irq_any !== 1'b0 || bus.rvalid !== 1'b0 || bus.rdata !== '0) begin
      failures++; $display("FAIL rstmid_out: got %b/%b/%b/%0h expected all 0", timer_interrupt, irq_any, bus.rvalid, bus.rdata);
    end
    idle(5);
    rd(1, d, v);
    checks++;
    if (d !== '0) begin failures++; $display("FAIL rstmid_mtime: got %0d expected 0", d); end
    rd(4, d, v);
    checks++;
    if (d !== 64'd25) begin failures++; $display("FAIL rstmid_cmp: got %0d expected 25", d); end
    rd(2, d, v);
    checks++;
    if (d !== '0) begin failures++; $display("FAIL rstmid_pend: got %0h expected 0", d); end
  endtask

  function automatic logic [WIDTH-1:0] gen_wdata(int unsigned a);
    logic [WIDTH-1:0] v;
    if (a == 0) v = (WIDTH'($urandom_range(0, 3)) << 8) | WIDTH'($urandom_range(0, 7) != 0);
    else if (a == 1) v = ($urandom_range(0, 9) == 0) ? ONES - WIDTH'($urandom_range(0, 3))
                                                     : WIDTH'($urandom_range(0, 60));
    else if (a == 2) v = WIDTH'($urandom_range(0, (1 << NUM_CH) - 1));
    else if (a >= 4 && (a - 4) % 3 == 0)
      v = ($urandom_range(0, 9) == 0) ? ONES - WIDTH'($urandom_range(0, 3))
                                      : m_mtime + WIDTH'($urandom_range(0, 30));
    else if (a >= 4 && (a - 4) % 3 == 1) v = WIDTH'($urandom_range(0, 6));
    else v = {$urandom(), $urandom()};
    return v;
  endfunction

  task automatic test_random();
    int unsigned op, sel, a;
    do_reset();
    for (int it = 0; it < 800; it++) begin
      op  = $urandom_range(0, 9);
      sel = $urandom_range(0, 3 + 3*NUM_CH);
      if (sel < 3) a = sel;
      else if (sel < 3 + 3*NUM_CH) a = sel + 1;
      else a = $urandom_range(0, 31);
      bus.addr  = ADDR_W'(a);
      bus.wdata = gen_wdata(a);
      bus.wr_en = (op >= 3 && op <= 5) || op == 9;
      bus.rd_en = op >= 6;
      step();
      bus.wr_en = 1'b0; bus.rd_en = 1'b0;
      checks++;
      if (timer_interrupt !== m_irq) begin
        failures++; $display("FAIL rand_irq@%0d: got %b expected %b", it, timer_interrupt, m_irq);
      end
      checks++;
      if (irq_any !== |m_irq) begin
        failures++; $display("FAIL rand_irq_any@%0d: got %b expected %b", it, irq_any, |m_irq);
      end
      checks++;
      if (bus.rvalid !== m_rvalid) begin
        failures++; $display("FAIL rand_rvalid@%0d: got %b expected %b", it, bus.rvalid, m_rvalid);
      end
      checks++;
      if (bus.rdata !== m_rdata) begin
        failures++; $display("FAIL rand_rdata@%0d addr %0d: got %0h expected %0h", it, a, bus.rdata, m_rdata);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    model_reset();
    test_reset();
    test_oneshot();
    test_prescale();
    test_periodic();
    test_w1c_race();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
